// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 8-bit-opcode CPU: fetches opcode plus two operand bytes,
// then steers register file, ALU and PC strobes, with memory wait states and illegal-op trapping.
module multicycle_control #(
  parameter int NREGS  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RSEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic              addr_sel,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] jmp_target,
  output logic [RSEL_W-1:0] rd_a_sel,
  output logic [RSEL_W-1:0] rd_b_sel,
  output logic [NREGS-1:0]  reg_we,
  output logic [1:0]        wr_src,
  output logic [DATA_W-1:0] lit_out,
  output logic              a_ld,
  output logic              b_ld,
  output logic              b_src,
  output logic              acc_ld,
  output logic [3:0]        alu_op,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal
);

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_MOV_RL = 8'h10;
  localparam logic [7:0] OPC_MOV_RR = 8'h11;
  localparam logic [7:0] OPC_MOV_MR = 8'h12;
  localparam logic [7:0] OPC_ADD_RL = 8'h20;
  localparam logic [7:0] OPC_ADD_RR = 8'h21;
  localparam logic [7:0] OPC_JMP    = 8'h30;
  localparam logic [7:0] OPC_HALT   = 8'hFF;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [NREGS-1:0] WE_ONE = NREGS'(1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_OP_LO, S_OP_HI, S_EXEC, S_ALU, S_WB, S_HALT, S_TRAP
  } state_t;

  state_t            state, next_state;
  logic [7:0]        op_lo, op_hi;
  logic [RSEL_W-1:0] d_sel, s_sel;
  logic [NREGS-1:0]  we_d;
  logic              is_add, has_operands, uses_src, bad_reg;

  assign d_sel        = op_lo[RSEL_W-1:0];
  assign s_sel        = op_hi[RSEL_W-1:0];
  assign we_d         = WE_ONE << d_sel;
  assign is_add       = (instr == OPC_ADD_RL) || (instr == OPC_ADD_RR);
  assign has_operands = instr inside {OPC_MOV_RL, OPC_MOV_RR, OPC_MOV_MR,
                                      OPC_ADD_RL, OPC_ADD_RR, OPC_JMP};
  assign uses_src     = instr inside {OPC_MOV_RR, OPC_MOV_MR, OPC_ADD_RR};
  // In OP_HI the source byte is still on the bus, so it is checked before it is latched.
  assign bad_reg      = ((instr != OPC_JMP) && !(int'(op_lo) < NREGS)) ||
                        (uses_src && !(int'(mem_rdata) < NREGS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      op_lo <= '0;
      op_hi <= '0;
    end else begin
      state <= next_state;
      if (state == S_OP_LO && mem_ready) op_lo <= mem_rdata;
      if (state == S_OP_HI && mem_ready) op_hi <= mem_rdata;
    end
  end

  // Handshake: mem_read/mem_write are held as a request; the transfer completes in any
  // cycle where the request is high and mem_ready is high. mem_ready is ignored otherwise.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (instr == OPC_NOP)       next_state = S_FETCH;
        else if (instr == OPC_HALT) next_state = S_HALT;
        else if (has_operands)      next_state = S_OP_LO;
        else                        next_state = S_TRAP;
      end
      S_OP_LO:  if (mem_ready) next_state = S_OP_HI;
      S_OP_HI:  if (mem_ready) next_state = bad_reg ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (instr == OPC_MOV_MR) next_state = mem_ready ? S_FETCH : S_EXEC;
        else if (is_add)         next_state = S_ALU;
        else                     next_state = S_FETCH;
      end
      S_ALU:    next_state = S_WB;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    jmp_target = '0;
    rd_a_sel   = '0;
    rd_b_sel   = '0;
    reg_we     = '0;
    wr_src     = 2'd0;
    lit_out    = '0;
    a_ld       = 1'b0;
    b_ld       = 1'b0;
    b_src      = 1'b0;
    acc_ld     = 1'b0;
    alu_op     = 4'd0;
    instr_done = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      lit_out    = DATA_W'(op_hi);
      jmp_target = ADDR_W'({op_hi, op_lo});
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_load  = mem_ready;
          pc_inc   = mem_ready;
        end
        S_DECODE: instr_done = (instr == OPC_NOP) || (instr == OPC_HALT);
        S_OP_LO, S_OP_HI: begin
          mem_read = 1'b1;
          pc_inc   = mem_ready;
        end
        S_EXEC: begin
          case (instr)
            OPC_MOV_RL: begin
              reg_we     = we_d;
              instr_done = 1'b1;
            end
            OPC_MOV_RR: begin
              rd_b_sel   = s_sel;
              wr_src     = 2'd1;
              reg_we     = we_d;
              instr_done = 1'b1;
            end
            OPC_MOV_MR: begin
              mem_write  = 1'b1;
              addr_sel   = 1'b1;
              rd_a_sel   = d_sel;
              rd_b_sel   = s_sel;
              instr_done = mem_ready;
            end
            OPC_ADD_RL: begin
              a_ld     = 1'b1;
              b_ld     = 1'b1;
              rd_a_sel = d_sel;
              b_src    = 1'b1;
            end
            OPC_ADD_RR: begin
              a_ld     = 1'b1;
              b_ld     = 1'b1;
              rd_a_sel = d_sel;
              rd_b_sel = s_sel;
            end
            OPC_JMP: begin
              pc_load    = 1'b1;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        S_ALU: acc_ld = 1'b1;
        S_WB: begin
          reg_we     = we_d;
          wr_src     = 2'd2;
          instr_done = 1'b1;
        end
        S_HALT: halted  = 1'b1;
        S_TRAP: illegal = 1'b1;
        default: ;
      endcase
      if (is_add && (state inside {S_EXEC, S_ALU, S_WB})) alu_op = OP_ADD;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-cycle expected trace of every output is built from an
// instruction-level model, queued, and compared cycle by cycle against the DUT.
module tb_multicycle_control;

  typedef struct packed {
    logic        mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load;
    logic [1:0]  rd_a_sel, rd_b_sel;
    logic [3:0]  reg_we;
    logic [1:0]  wr_src;
    logic        a_ld, b_ld, b_src, acc_ld;
    logic [3:0]  alu_op;
    logic        instr_done, halted, illegal;
    logic [15:0] lit_out, jmp_target;
  } obs_t;

  localparam int SW = $bits(obs_t);

  typedef struct {
    logic [7:0] op, lo, hi;
    int         wf, we, lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  instr = 8'h00;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load;
  logic [15:0] jmp_target, lit_out;
  logic [1:0]  rd_a_sel, rd_b_sel, wr_src;
  logic [3:0]  reg_we, alu_op;
  logic        a_ld, b_ld, b_src, acc_ld, instr_done, halted, illegal;

  logic [SW-1:0] exp_q[$];
  logic [7:0]    d_q[$];
  logic          rdy_q[$];
  logic          rst_q[$];

  logic [7:0] m_lo = 8'h00;
  logic [7:0] m_hi = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         done_at = -1;
  string      tag = "reset";
  vec_t       vecs[12];

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .jmp_target(jmp_target), .rd_a_sel(rd_a_sel),
    .rd_b_sel(rd_b_sel), .reg_we(reg_we), .wr_src(wr_src), .lit_out(lit_out),
    .a_ld(a_ld), .b_ld(b_ld), .b_src(b_src), .acc_ld(acc_ld), .alu_op(alu_op),
    .instr_done(instr_done), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_cyc(input obs_t e, input logic [7:0] d, input logic rdy, input logic rs);
    obs_t x;
    x = e;
    if (rs) x = '0;
    else begin
      x.lit_out    = {8'h00, m_hi};
      x.jmp_target = {m_hi, m_lo};
    end
    exp_q.push_back(x);
    d_q.push_back(d);
    rdy_q.push_back(rdy);
    rst_q.push_back(rs);
  endtask

  task automatic push_reset();
    push_cyc('0, rnd_byte(), rnd_bit(), 1'b1);
    m_lo = 8'h00;
    m_hi = 8'h00;
  endtask

  task automatic add_read(input obs_t e, input logic [7:0] d, input int waits);
    obs_t w;
    w = '0;
    w.mem_read = 1'b1;
    for (int i = 0; i < waits; i++) push_cyc(w, rnd_byte(), 1'b0, 1'b0);
    push_cyc(e, d, 1'b1, 1'b0);
  endtask

  // Instruction-level model producing the expected per-cycle outputs.
  task automatic add_instr(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                           input int wf, input int we);
    obs_t e;
    logic uses_s, bad;
    e = '0; e.mem_read = 1'b1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
    add_read(e, op, wf);
    e = '0;
    if (op == 8'h00 || op == 8'hFF) begin
      e.instr_done = 1'b1;
      push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
      return;
    end
    push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
    if (!(op inside {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h30})) return;
    e = '0; e.mem_read = 1'b1; e.pc_inc = 1'b1;
    add_read(e, lo, wf);
    m_lo = lo;
    add_read(e, hi, wf);
    m_hi = hi;
    uses_s = op inside {8'h11, 8'h12, 8'h21};
    bad = (op != 8'h30 && lo >= 8'd4) || (uses_s && hi >= 8'd4);
    if (bad) return;
    e = '0;
    case (op)
      8'h10: begin
        e.reg_we = 4'b0001 << lo[1:0]; e.instr_done = 1'b1;
        push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
      end
      8'h11: begin
        e.rd_b_sel = hi[1:0]; e.wr_src = 2'd1; e.reg_we = 4'b0001 << lo[1:0]; e.instr_done = 1'b1;
        push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
      end
      8'h30: begin
        e.pc_load = 1'b1; e.instr_done = 1'b1;
        push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
      end
      8'h12: begin
        e.mem_write = 1'b1; e.addr_sel = 1'b1; e.rd_a_sel = lo[1:0]; e.rd_b_sel = hi[1:0];
        for (int i = 0; i < we; i++) push_cyc(e, rnd_byte(), 1'b0, 1'b0);
        e.instr_done = 1'b1;
        push_cyc(e, rnd_byte(), 1'b1, 1'b0);
      end
      default: begin
        e.a_ld = 1'b1; e.b_ld = 1'b1; e.rd_a_sel = lo[1:0]; e.alu_op = 4'd1;
        if (op == 8'h20) e.b_src = 1'b1;
        else e.rd_b_sel = hi[1:0];
        push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
        e = '0; e.acc_ld = 1'b1; e.alu_op = 4'd1;
        push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
        e = '0; e.reg_we = 4'b0001 << lo[1:0]; e.wr_src = 2'd2; e.alu_op = 4'd1; e.instr_done = 1'b1;
        push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
      end
    endcase
  endtask

  task automatic add_idle(input obs_t e, input int n);
    for (int i = 0; i < n; i++) push_cyc(e, rnd_byte(), rnd_bit(), 1'b0);
  endtask

  // Entered just after a rising edge; drives one cycle, checks at the falling edge.
  task automatic run_cycle();
    obs_t e, a;
    logic [7:0] d;
    logic ld;
    e = obs_t'(exp_q.pop_front());
    d = d_q.pop_front();
    reset = rst_q.pop_front();
    mem_rdata = d;
    mem_ready = rdy_q.pop_front();
    @(negedge clk);
    a = '{mem_read, mem_write, addr_sel, ir_load, pc_inc, pc_load, rd_a_sel, rd_b_sel,
          reg_we, wr_src, a_ld, b_ld, b_src, acc_ld, alu_op, instr_done, halted, illegal,
          lit_out, jmp_target};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: outputs got %h expected %h", tag, cyc, a, e);
    end
    if (a.instr_done && done_at < 0) done_at = cyc;
    cyc++;
    ld = ir_load;
    @(posedge clk);
    #1;
    if (ld) instr = d;
  endtask

  task automatic run_all();
    while (exp_q.size() > 0) run_cycle();
  endtask

  initial begin
    vecs[0]  = '{8'h10, 8'h02, 8'h5A, 0, 0, 5};
    vecs[1]  = '{8'h21, 8'h01, 8'h03, 0, 0, 7};
    vecs[2]  = '{8'h12, 8'h00, 8'h01, 0, 3, 8};
    vecs[3]  = '{8'h00, 8'h00, 8'h00, 0, 0, 2};
    vecs[4]  = '{8'h11, 8'h03, 8'h02, 0, 0, 5};
    vecs[5]  = '{8'h20, 8'h02, 8'hFF, 1, 0, 10};
    vecs[6]  = '{8'h12, 8'h03, 8'h00, 0, 0, 5};
    vecs[7]  = '{8'h30, 8'h78, 8'h56, 2, 0, 11};
    vecs[8]  = '{8'h11, 8'h00, 8'h01, 0, 0, 5};
    vecs[9]  = '{8'h21, 8'h03, 8'h03, 0, 0, 7};
    vecs[10] = '{8'h00, 8'h00, 8'h00, 2, 0, 4};
    vecs[11] = '{8'h10, 8'h01, 8'h00, 0, 0, 5};

    push_reset();
    push_reset();
    run_all();

    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d_op%h", i, vecs[i].op);
      cyc = 0;
      done_at = -1;
      add_instr(vecs[i].op, vecs[i].lo, vecs[i].hi, vecs[i].wf, vecs[i].we);
      run_all();
      checks++;
      if (done_at + 1 != vecs[i].lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", tag, done_at + 1, vecs[i].lat);
      end
    end

    // Reset asserted during the ALU cycle of an ADD, then a fetch with one wait state.
    tag = "reset_in_alu";
    cyc = 0;
    add_instr(8'h20, 8'h01, 8'h07, 0, 0);
    repeat (2) begin
      void'(exp_q.pop_back());
      void'(d_q.pop_back());
      void'(rdy_q.pop_back());
      void'(rst_q.pop_back());
    end
    push_reset();
    add_instr(8'h00, 8'h00, 8'h00, 1, 0);
    run_all();

    // JMP then HALT; halted is sticky and no further reads are requested.
    tag = "jmp_halt";
    cyc = 0;
    add_instr(8'h30, 8'h34, 8'h12, 0, 0);
    add_instr(8'hFF, 8'h00, 8'h00, 0, 0);
    add_idle('{halted: 1'b1, default: '0}, 4);
    push_reset();
    run_all();

    tag = "trap_opcode";
    cyc = 0;
    add_instr(8'h7E, 8'h00, 8'h00, 0, 0);
    add_idle('{illegal: 1'b1, default: '0}, 4);
    push_reset();
    run_all();

    tag = "trap_regop";
    cyc = 0;
    add_instr(8'h10, 8'h04, 8'h55, 0, 0);
    add_idle('{illegal: 1'b1, default: '0}, 4);
    push_reset();
    add_instr(8'h00, 8'h00, 8'h00, 0, 0);
    run_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
